// File: rtl/axi_id_order_tracker.sv
// rtl/axi_id_order_tracker.sv - per-ID in-flight count/select tracker enforcing AXI same-ID ordering
// Optional underflow error reporting is built when AXI_ID_TRACK_ERR_EN is defined.
module axi_id_order_tracker #(
   parameter int unsigned IdBits   = 3,
   parameter int unsigned MaxTrans = 8,
   parameter int unsigned MaxPerId = 4,
   parameter type         select_t = logic,
   parameter int unsigned CntW     = $clog2(MaxTrans + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_valid_i,
   output logic              push_ready_o,
   input  logic [IdBits-1:0] push_id_i,
   input  select_t           push_sel_i,
   input  logic              pop_valid_i,
   input  logic [IdBits-1:0] pop_id_i,
   input  logic [IdBits-1:0] lookup_id_i,
   output logic              lookup_taken_o,
   output select_t           lookup_sel_o,
   output logic [CntW-1:0]   lookup_cnt_o,
   input  logic [IdBits-1:0] atomic_id_i,
   output logic              atomic_taken_o,
   output logic [CntW-1:0]   total_cnt_o,
   output logic              full_o,
   output logic              idle_o,
   input  logic              clear_err_i,
   output logic              err_o,
   output logic [IdBits-1:0] err_id_o
);

   localparam int unsigned     NoIds     = 2**IdBits;
   localparam logic [CntW-1:0] MaxTransC = CntW'(MaxTrans);
   localparam logic [CntW-1:0] MaxPerIdC = CntW'(MaxPerId);

   logic [CntW-1:0] cnt_q [NoIds];
   select_t         sel_q [NoIds];
   logic [CntW-1:0] total_q;
   logic            push_fire;
   logic            pop_legal;
   logic [NoIds-1:0] inc_vec;
   logic [NoIds-1:0] dec_vec;

   // Ready depends only on registered state: a pop in this cycle never frees space for this cycle's push.
   assign push_ready_o = !full_o &&
                         ((cnt_q[push_id_i] == '0) ||
                          ((sel_q[push_id_i] == push_sel_i) && (cnt_q[push_id_i] < MaxPerIdC)));
   assign push_fire    = push_valid_i && push_ready_o;
   assign pop_legal    = pop_valid_i && (cnt_q[pop_id_i] != '0);

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (push_fire) inc_vec[push_id_i] = 1'b1;
      if (pop_legal) dec_vec[pop_id_i]  = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NoIds; i++) begin
            cnt_q[i] <= '0;
            sel_q[i] <= '0;
         end
         total_q <= '0;
      end else begin
         for (int i = 0; i < NoIds; i++) begin
            if (inc_vec[i] && !dec_vec[i])
               cnt_q[i] <= cnt_q[i] + CntW'(1);
            else if (dec_vec[i] && !inc_vec[i])
               cnt_q[i] <= cnt_q[i] - CntW'(1);
            // Select is latched only when the ID goes from idle to taken; it is left stale after drain.
            if (inc_vec[i] && (cnt_q[i] == '0))
               sel_q[i] <= push_sel_i;
         end
         if (push_fire && !pop_legal)
            total_q <= total_q + CntW'(1);
         else if (pop_legal && !push_fire)
            total_q <= total_q - CntW'(1);
      end
   end

   assign lookup_taken_o = (cnt_q[lookup_id_i] != '0);
   assign lookup_sel_o   = sel_q[lookup_id_i];
   assign lookup_cnt_o   = cnt_q[lookup_id_i];
   assign atomic_taken_o = (cnt_q[atomic_id_i] != '0);
   assign total_cnt_o    = total_q;
   assign full_o         = (total_q == MaxTransC);
   assign idle_o         = (total_q == '0);

`ifdef AXI_ID_TRACK_ERR_EN
   logic              pop_illegal;
   logic              err_q;
   logic [IdBits-1:0] err_id_q;

   assign pop_illegal = pop_valid_i && (cnt_q[pop_id_i] == '0);

   // A new underflow wins over a clear in the same cycle and re-captures the ID.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q    <= 1'b0;
         err_id_q <= '0;
      end else if (pop_illegal) begin
         err_q <= 1'b1;
         if (!err_q || clear_err_i)
            err_id_q <= pop_id_i;
      end else if (clear_err_i) begin
         err_q    <= 1'b0;
         err_id_q <= '0;
      end
   end

   assign err_o    = err_q;
   assign err_id_o = err_id_q;

`ifndef SYNTHESIS
   illegal_pop_a: assert property (@(posedge clk_i) disable iff (rst_i) !pop_illegal);
`endif
`else
   logic unused_clear_err;
   assign unused_clear_err = clear_err_i;
   assign err_o            = 1'b0;
   assign err_id_o         = '0;
`endif

endmodule

// File: tb/tb_axi_id_order_tracker.sv
// tb/tb_axi_id_order_tracker.sv - scoreboard bench for axi_id_order_tracker
module tb_axi_id_order_tracker;

`ifdef AXI_ID_TRACK_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       push_valid_i = 1'b0;
   logic       push_ready_o;
   logic [2:0] push_id_i = '0;
   logic [1:0] push_sel_i = '0;
   logic       pop_valid_i = 1'b0;
   logic [2:0] pop_id_i = '0;
   logic [2:0] lookup_id_i = '0;
   logic       lookup_taken_o;
   logic [1:0] lookup_sel_o;
   logic [3:0] lookup_cnt_o;
   logic [2:0] atomic_id_i = '0;
   logic       atomic_taken_o;
   logic [3:0] total_cnt_o;
   logic       full_o;
   logic       idle_o;
   logic       clear_err_i = 1'b0;
   logic       err_o;
   logic [2:0] err_id_o;

   axi_id_order_tracker #(
      .IdBits  (3),
      .MaxTrans(8),
      .MaxPerId(4),
      .select_t(logic [1:0])
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .push_valid_i  (push_valid_i),
      .push_ready_o  (push_ready_o),
      .push_id_i     (push_id_i),
      .push_sel_i    (push_sel_i),
      .pop_valid_i   (pop_valid_i),
      .pop_id_i      (pop_id_i),
      .lookup_id_i   (lookup_id_i),
      .lookup_taken_o(lookup_taken_o),
      .lookup_sel_o  (lookup_sel_o),
      .lookup_cnt_o  (lookup_cnt_o),
      .atomic_id_i   (atomic_id_i),
      .atomic_taken_o(atomic_taken_o),
      .total_cnt_o   (total_cnt_o),
      .full_o        (full_o),
      .idle_o        (idle_o),
      .clear_err_i   (clear_err_i),
      .err_o         (err_o),
      .err_id_o      (err_id_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [2:0] lid;
      logic       tk;
      logic [3:0] cnt;
      logic [1:0] sel;
      logic       atk;
      logic [3:0] tot;
      logic       full;
      logic       idle;
      logic       err;
      logic [2:0] eid;
   } exp_t;

   exp_t q_state[$];
   logic q_rdy[$];
   int   pass_cnt = 0;
   int   tot_cnt  = 0;

   int         m_cnt [8];
   logic [1:0] m_sel [8];
   int         m_total;
   logic       m_err;
   logic [2:0] m_eid;

   // Ready is compared mid-cycle, after the driver has settled the inputs.
   always @(negedge clk_i) begin
      if (q_rdy.size() > 0) begin
         logic r;
         r = q_rdy.pop_front();
         tot_cnt++;
         if (push_ready_o !== r) $display("FAIL sb_ready: got %b want %b at %0t", push_ready_o, r, $time);
         else pass_cnt++;
      end
   end

   always @(posedge clk_i) begin
      #1;
      if (q_state.size() > 0) begin
         exp_t e;
         e = q_state.pop_front();
         tot_cnt++;
         if ({lookup_taken_o, lookup_cnt_o, lookup_sel_o, atomic_taken_o} !== {e.tk, e.cnt, e.sel, e.atk})
            $display("FAIL sb_lookup id%0d: got tk=%b cnt=%0d sel=%0d atk=%b want tk=%b cnt=%0d sel=%0d atk=%b at %0t",
                     e.lid, lookup_taken_o, lookup_cnt_o, lookup_sel_o, atomic_taken_o, e.tk, e.cnt, e.sel, e.atk, $time);
         else pass_cnt++;
         tot_cnt++;
         if ({total_cnt_o, full_o, idle_o, err_o, err_id_o} !== {e.tot, e.full, e.idle, e.err, e.eid})
            $display("FAIL sb_global: got tot=%0d full=%b idle=%b err=%b eid=%0d want tot=%0d full=%b idle=%b err=%b eid=%0d at %0t",
                     total_cnt_o, full_o, idle_o, err_o, err_id_o, e.tot, e.full, e.idle, e.err, e.eid, $time);
         else pass_cnt++;
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_cnt[i] = 0;
         m_sel[i] = '0;
      end
      m_total = 0;
      m_err   = 1'b0;
      m_eid   = '0;
   endtask

   task automatic idle_inputs();
      push_valid_i = 1'b0;
      pop_valid_i  = 1'b0;
      clear_err_i  = 1'b0;
   endtask

   // One clock cycle: drive inputs, predict with the model, queue expectations, advance to edge+2.
   task automatic step(input logic pv, input logic [2:0] pid, input logic [1:0] psel,
                       input logic popv, input logic [2:0] popid, input logic clr,
                       input logic [2:0] lid, output logic acc);
      exp_t e;
      logic rdy, legal;
      push_valid_i = pv;   push_id_i   = pid;   push_sel_i  = psel;
      pop_valid_i  = popv; pop_id_i    = popid; clear_err_i = clr;
      lookup_id_i  = lid;  atomic_id_i = lid ^ 3'd1;
      rdy   = (m_total != 8) && ((m_cnt[pid] == 0) || ((m_sel[pid] == psel) && (m_cnt[pid] < 4)));
      acc   = pv && rdy;
      legal = popv && (m_cnt[popid] != 0);
      if (ERR_EN) begin
         if (popv && !legal) begin
            if (!m_err || clr) m_eid = popid;
            m_err = 1'b1;
         end else if (clr) begin
            m_err = 1'b0;
            m_eid = '0;
         end
      end
      if (acc) begin
         if (m_cnt[pid] == 0) m_sel[pid] = psel;
         m_cnt[pid]++;
         m_total++;
      end
      if (legal) begin
         m_cnt[popid]--;
         m_total--;
      end
      e.lid  = lid;
      e.tk   = (m_cnt[lid] != 0);
      e.cnt  = 4'(m_cnt[lid]);
      e.sel  = m_sel[lid];
      e.atk  = (m_cnt[lid ^ 3'd1] != 0);
      e.tot  = 4'(m_total);
      e.full = (m_total == 8);
      e.idle = (m_total == 0);
      e.err  = m_err;
      e.eid  = m_eid;
      q_rdy.push_back(rdy);
      q_state.push_back(e);
      @(posedge clk_i);
      #2;
   endtask

   task automatic test_reset();
      model_reset();
      idle_inputs();
      #1;
      tot_cnt++;
      if ({push_ready_o, lookup_taken_o, lookup_sel_o, lookup_cnt_o, atomic_taken_o} !== {1'b1, 1'b0, 2'd0, 4'd0, 1'b0})
         $display("FAIL reset_lookup: got rdy=%b tk=%b sel=%0d cnt=%0d atk=%b want 1 0 0 0 0",
                  push_ready_o, lookup_taken_o, lookup_sel_o, lookup_cnt_o, atomic_taken_o);
      else pass_cnt++;
      tot_cnt++;
      if ({total_cnt_o, full_o, idle_o, err_o, err_id_o} !== {4'd0, 1'b0, 1'b1, 1'b0, 3'd0})
         $display("FAIL reset_global: got tot=%0d full=%b idle=%b err=%b eid=%0d want 0 0 1 0 0",
                  total_cnt_o, full_o, idle_o, err_o, err_id_o);
      else pass_cnt++;
      #6 rst_i = 1'b0;
      @(posedge clk_i);
      #2;
   endtask

   task automatic test_basic_push();
      logic acc;
      for (int i = 0; i < 3; i++) step(1'b1, 3'd2, 2'd1, 1'b0, 3'd0, 1'b0, 3'd2, acc);
      tot_cnt++;
      if ({lookup_taken_o, lookup_cnt_o, lookup_sel_o, total_cnt_o, idle_o} !== {1'b1, 4'd3, 2'd1, 4'd3, 1'b0})
         $display("FAIL basic_push: got tk=%b cnt=%0d sel=%0d tot=%0d idle=%b want 1 3 1 3 0",
                  lookup_taken_o, lookup_cnt_o, lookup_sel_o, total_cnt_o, idle_o);
      else pass_cnt++;
   endtask

   task automatic test_ordering();
      logic acc;
      push_valid_i = 1'b1; push_id_i = 3'd2; push_sel_i = 2'd0;
      #1;
      tot_cnt++;
      if (push_ready_o !== 1'b0) $display("FAIL order_block: got ready=%b want 0", push_ready_o);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) step(1'b1, 3'd2, 2'd0, 1'b1, 3'd2, 1'b0, 3'd2, acc);
      pop_valid_i = 1'b0;
      #1;
      tot_cnt++;
      if (push_ready_o !== 1'b1) $display("FAIL order_release: got ready=%b want 1", push_ready_o);
      else pass_cnt++;
      step(1'b1, 3'd2, 2'd0, 1'b0, 3'd0, 1'b0, 3'd2, acc);
      tot_cnt++;
      if ({lookup_cnt_o, lookup_sel_o} !== {4'd1, 2'd0})
         $display("FAIL order_resel: got cnt=%0d sel=%0d want 1 0", lookup_cnt_o, lookup_sel_o);
      else pass_cnt++;
   endtask

   task automatic test_per_id_limit();
      logic acc;
      for (int i = 0; i < 4; i++) step(1'b1, 3'd5, 2'd3, 1'b0, 3'd0, 1'b0, 3'd5, acc);
      push_valid_i = 1'b1; push_id_i = 3'd5; push_sel_i = 2'd3;
      #1;
      tot_cnt++;
      if (push_ready_o !== 1'b0) $display("FAIL per_id_limit: got ready=%b want 0", push_ready_o);
      else pass_cnt++;
      push_id_i = 3'd6; push_sel_i = 2'd0;
      #1;
      tot_cnt++;
      if (push_ready_o !== 1'b1) $display("FAIL per_id_other: got ready=%b want 1", push_ready_o);
      else pass_cnt++;
      step(1'b1, 3'd6, 2'd0, 1'b0, 3'd0, 1'b0, 3'd5, acc);
   endtask

   task automatic test_full();
      logic acc;
      for (int i = 0; i < 2; i++) step(1'b1, 3'd7, 2'd1, 1'b0, 3'd0, 1'b0, 3'd7, acc);
      push_valid_i = 1'b1; push_id_i = 3'd0; push_sel_i = 2'd0;
      #1;
      tot_cnt++;
      if ({full_o, total_cnt_o, push_ready_o} !== {1'b1, 4'd8, 1'b0})
         $display("FAIL full_block: got full=%b tot=%0d ready=%b want 1 8 0", full_o, total_cnt_o, push_ready_o);
      else pass_cnt++;
      step(1'b1, 3'd0, 2'd0, 1'b1, 3'd5, 1'b0, 3'd0, acc);
      tot_cnt++;
      if ({total_cnt_o, lookup_taken_o} !== {4'd7, 1'b0})
         $display("FAIL full_pop_no_bypass: got tot=%0d tk=%b want 7 0", total_cnt_o, lookup_taken_o);
      else pass_cnt++;
      step(1'b1, 3'd0, 2'd0, 1'b0, 3'd0, 1'b0, 3'd0, acc);
      tot_cnt++;
      if ({total_cnt_o, full_o, lookup_taken_o} !== {4'd8, 1'b1, 1'b1})
         $display("FAIL full_retry: got tot=%0d full=%b tk=%b want 8 1 1", total_cnt_o, full_o, lookup_taken_o);
      else pass_cnt++;
   endtask

   task automatic test_same_cycle();
      logic acc;
      for (int i = 0; i < 2; i++) step(1'b0, 3'd0, 2'd0, 1'b1, 3'd7, 1'b0, 3'd7, acc);
      step(1'b1, 3'd1, 2'd2, 1'b0, 3'd0, 1'b0, 3'd1, acc);
      step(1'b1, 3'd1, 2'd2, 1'b1, 3'd1, 1'b0, 3'd1, acc);
      tot_cnt++;
      if ({lookup_cnt_o, lookup_sel_o, total_cnt_o} !== {4'd1, 2'd2, 4'd7})
         $display("FAIL same_cycle: got cnt=%0d sel=%0d tot=%0d want 1 2 7", lookup_cnt_o, lookup_sel_o, total_cnt_o);
      else pass_cnt++;
   endtask

   task automatic test_illegal_pop();
      logic acc;
      step(1'b0, 3'd0, 2'd0, 1'b1, 3'd4, 1'b0, 3'd4, acc);
      tot_cnt++;
      if ({lookup_cnt_o, total_cnt_o, err_o, err_id_o} !== {4'd0, 4'd7, ERR_EN, ERR_EN ? 3'd4 : 3'd0})
         $display("FAIL illegal_pop: got cnt=%0d tot=%0d err=%b eid=%0d want 0 7 %b %0d",
                  lookup_cnt_o, total_cnt_o, err_o, err_id_o, ERR_EN, ERR_EN ? 4 : 0);
      else pass_cnt++;
      step(1'b0, 3'd0, 2'd0, 1'b1, 3'd3, 1'b0, 3'd3, acc);
      tot_cnt++;
      if ({err_o, err_id_o} !== {ERR_EN, ERR_EN ? 3'd4 : 3'd0})
         $display("FAIL err_sticky: got err=%b eid=%0d want %b %0d", err_o, err_id_o, ERR_EN, ERR_EN ? 4 : 0);
      else pass_cnt++;
      step(1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 1'b1, 3'd3, acc);
      tot_cnt++;
      if ({err_o, err_id_o} !== {1'b0, 3'd0})
         $display("FAIL err_clear: got err=%b eid=%0d want 0 0", err_o, err_id_o);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic acc;
      step(1'b0, 3'd0, 2'd0, 1'b1, 3'd1, 1'b0, 3'd5, acc);
      tot_cnt++;
      if (total_cnt_o !== 4'd6) $display("FAIL mid_pre_total: got %0d want 6", total_cnt_o);
      else pass_cnt++;
      rst_i = 1'b1;
      #1;
      tot_cnt++;
      if ({total_cnt_o, idle_o, full_o, lookup_taken_o, lookup_cnt_o, lookup_sel_o, push_ready_o} !==
          {4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1})
         $display("FAIL mid_reset: got tot=%0d idle=%b full=%b tk=%b cnt=%0d sel=%0d rdy=%b want 0 1 0 0 0 0 1",
                  total_cnt_o, idle_o, full_o, lookup_taken_o, lookup_cnt_o, lookup_sel_o, push_ready_o);
      else pass_cnt++;
      idle_inputs();
      model_reset();
      #2 rst_i = 1'b0;
      @(posedge clk_i);
      #2;
      step(1'b1, 3'd3, 2'd1, 1'b0, 3'd0, 1'b0, 3'd3, acc);
      tot_cnt++;
      if ({lookup_cnt_o, total_cnt_o} !== {4'd1, 4'd1})
         $display("FAIL mid_first_push: got cnt=%0d tot=%0d want 1 1", lookup_cnt_o, total_cnt_o);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic acc, popv;
      logic [2:0] popid;
      for (int n = 0; n < 300; n++) begin
         popid = 3'($urandom_range(0, 7));
         popv  = ($urandom_range(0, 2) != 0) && (m_cnt[popid] != 0);
         step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 1)),
              popv, popid, ($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)), acc);
      end
   endtask

   initial begin
      test_reset();
      test_basic_push();
      test_ordering();
      test_per_id_limit();
      test_full();
      test_same_cycle();
      test_illegal_pop();
      test_reset_mid();
      test_back_to_back();
      idle_inputs();
      @(posedge clk_i);
      #3;
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/axi_id_order_tracker.md
# axi_id_order_tracker

Per-ID in-flight transaction tracker for the crossbar demux, the next generation of the ID in-flight array. It records, for every AXI ID value, how many transactions are outstanding and which select (master port) they were routed to. It enforces AXI same-ID ordering by back-pressuring a push whose ID is already in flight to a different select. Compared with the previous block it adds:

- a valid/ready push handshake;
- per-ID and global saturation limits;
- a registered total count;
- optional underflow error reporting.

## Interface
Parameters:
- IdBits, 3, number of ID bits tracked; NoIds = 2**IdBits
- MaxTrans, 8, global outstanding limit across all IDs (>=1)
- MaxPerId, 4, outstanding limit per ID (1..MaxTrans)
- select_t, logic, type of the routing select stored per ID
- CntW, $clog2(MaxTrans+1), derived; width of count outputs

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- push_valid_i  in  1  request to record a new transaction
- push_ready_o  out  1  push accepted this cycle when high with push_valid_i
- push_id_i  in  IdBits  ID of pushed transaction
- push_sel_i  in  select_t  select of pushed transaction
- pop_valid_i  in  1  one transaction of pop_id_i completed (always accepted)
- pop_id_i  in  IdBits  ID being retired
- lookup_id_i  in  IdBits  ID to query
- lookup_taken_o  out  1  lookup ID has count > 0
- lookup_sel_o  out  select_t  stored select of lookup ID
- lookup_cnt_o  out  CntW  outstanding count of lookup ID
- atomic_id_i  in  IdBits  second query port (ATOP R/W ID check)
- atomic_taken_o  out  1  atomic ID has count > 0
- total_cnt_o  out  CntW  total outstanding, registered
- full_o  out  1  total_cnt_o == MaxTrans
- idle_o  out  1  total_cnt_o == 0
- clear_err_i  in  1  clears sticky error
- err_o  out  1  sticky underflow error
- err_id_o  out  IdBits  ID of first underflowing pop

## Operation
- State:
  - per ID: cnt[i] (CntW bits) and sel[i] (select_t);
  - global: total (CntW) and error registers.
- push_ready_o = !full_o && (cnt[push_id_i]==0 || (sel[push_id_i]==push_sel_i && cnt[push_id_i]<MaxPerId)).
  - Combinational from registered state and push inputs only.
  - Independent of pop inputs: there is no same-cycle pop bypass.
- Push accepted (valid && ready):
  - cnt[push_id] increments.
  - sel[push_id] is written with push_sel_i only when the pre-cycle cnt was 0; otherwise it is unchanged.
- Pop with pre-cycle cnt[pop_id] > 0: cnt decrements. sel is left stale; it is only meaningful while taken.
- Pop with pre-cycle cnt[pop_id] == 0 is illegal:
  - cnt is unchanged and total is unchanged.
  - The error is handled per Configuration.
- Simultaneous accepted push and legal pop on the same ID: cnt unchanged, sel unchanged, total unchanged.
- Simultaneous push and pop on different IDs: each ID updates independently; total unchanged.
- total tracks the sum of all cnt[i] at every cycle boundary.
  - It is maintained incrementally (+1 per push, -1 per legal pop); there is no adder tree.
  - It never exceeds MaxTrans and never wraps.
- lookup_* and atomic_taken_o are combinational reads of the registered arrays.
- Unused ID values are not special; every ID 0..NoIds-1 is tracked.

## Timing
- Reset (rst_i high, asynchronous assert) clears all state:
  - all cnt = 0, all sel = '0, total = 0.
  - push_ready_o = 1 (given full_o = 0).
  - lookup_taken_o = 0, lookup_sel_o = '0, lookup_cnt_o = 0, atomic_taken_o = 0.
  - total_cnt_o = 0, full_o = 0, idle_o = 1, err_o = 0, err_id_o = 0.
- Reset mid-operation discards all outstanding records. No pop is required afterwards.
- Latency:
  - A push or pop accepted in cycle N is visible on all count, taken, sel, full and idle outputs in cycle N+1.
  - push_ready_o in cycle N+1 reflects the update.
- A pop arriving in the same cycle as full does not free space for a push in that cycle. The push retries in N+1.
- The push handshake is single-cycle. The requester may drop push_valid_i at any time; no state is changed unless a push is accepted.

## Configuration
- Macro: AXI_ID_TRACK_ERR_EN.
- Defined:
  - An illegal pop sets err_o in cycle N+1.
  - The first illegal pop captures its ID in err_id_o; later illegal pops do not overwrite it.
  - clear_err_i clears both registers at the next edge. If clear and illegal pop occur in the same cycle, the set wins and err_id_o takes the new ID.
  - An SVA assertion fires on illegal pop (synthesis off).
- Undefined:
  - Illegal pops are silently ignored.
  - err_o and err_id_o are tied to 0 and clear_err_i is unused.
  - No error registers are built.

## Test plan
- Reset, then push id=2 sel=1 three times -> lookup(2): taken=1, cnt=3, sel=1; total_cnt_o=3; idle_o=0.
- With id=2 in flight on sel=1, push id=2 sel=0 -> push_ready_o=0. Pop id=2 three times -> ready=1 in the cycle after the last pop; the push is accepted and sel[2] becomes 0.
- Push id=5 sel=3 MaxPerId=4 times -> 5th push ready=0. Push id=6 is still accepted.
- Fill to MaxTrans=8 across IDs -> full_o=1 and all pushes blocked. Pop and push in the same cycle -> push not accepted; accepted the next cycle; total stays 8.
- Same cycle: push id=1 and legal pop id=1 -> cnt[1] and total unchanged. Pop id=4 with cnt 0 -> counts unchanged; with AXI_ID_TRACK_ERR_EN, err_o=1 and err_id_o=4 until clear_err_i.
- Assert rst_i mid-traffic with total=6 -> all outputs return to reset values asynchronously; the first push after release is accepted.
